// File: rtl/operand_sequencer.sv
// Byte-stream front end for the 8-bit ALU: collects opcode/A/B, waits ALU_LATENCY cycles, returns the result.
// InReady is low while executing or holding a result; the result is held in SEND until OutReady accepts it.
module operand_sequencer #(
  parameter int WIDTH       = 8,
  parameter int NUM_OPS     = 8,
  parameter int ALU_LATENCY = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] InData,
  input  logic             InValid,
  output logic             InReady,
  output logic [2:0]       OpSel,
  output logic [WIDTH-1:0] In1,
  output logic [WIDTH-1:0] In2,
  input  logic [WIDTH-1:0] AluOut,
  output logic [WIDTH-1:0] OutData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Busy,
  output logic             Error,
  output logic [1:0]       ErrCode
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_SEND
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [2:0]       op_sel_q, op_sel_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [LW-1:0]    lat_cnt_q, lat_cnt_d;

  logic in_accept;
  logic out_accept;
  logic op_ok;
  logic expired;

  assign in_accept  = InValid && in_ready_q;
  assign out_accept = out_valid_q && OutReady;
  assign op_ok      = (32'(InData) < NUM_OPS);
  assign expired    = (idle_cnt_q == IW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    error_d     = 1'b0;
    err_code_d  = err_code_q;
    op_sel_d    = op_sel_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    out_data_d  = out_data_q;
    idle_cnt_d  = idle_cnt_q;
    lat_cnt_d   = lat_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_accept) begin
          if (op_ok) begin
            op_sel_d   = InData[2:0];
            idle_cnt_d = '0;
            state_d    = S_GET_A;
          end else begin
            error_d    = 1'b1;
            err_code_d = 2'd1;
          end
        end
      end
      S_GET_A, S_GET_B: begin
        // An accept on the expiry cycle takes priority over the timeout.
        if (in_accept) begin
          idle_cnt_d = '0;
          if (state_q == S_GET_A) begin
            in1_d   = InData;
            state_d = S_GET_B;
          end else begin
            in2_d     = InData;
            lat_cnt_d = LW'(ALU_LATENCY);
            state_d   = S_EXEC;
          end
        end else if (expired) begin
          idle_cnt_d = '0;
          error_d    = 1'b1;
          err_code_d = 2'd2;
          state_d    = S_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      S_EXEC: begin
        lat_cnt_d = lat_cnt_q - LW'(1);
        if (lat_cnt_q == LW'(1)) begin
          out_data_d  = AluOut;
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (out_accept) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_GET_A) || (state_d == S_GET_B);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
      op_sel_q    <= 3'd0;
      in1_q       <= '0;
      in2_q       <= '0;
      out_data_q  <= '0;
      idle_cnt_q  <= '0;
      lat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      op_sel_q    <= op_sel_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      out_data_q  <= out_data_d;
      idle_cnt_q  <= idle_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign Busy     = busy_q;
  assign Error    = error_q;
  assign ErrCode  = err_code_q;
  assign OpSel    = op_sel_q;
  assign In1      = in1_q;
  assign In2      = in2_q;
  assign OutData  = out_data_q;

endmodule
